// File: rtl/eco32f_fetch_if.sv
// Instruction-bus bundle between eco32f_fetch (master) and the memory side (slave).
// Single outstanding word read: req/adr held until ack or err.
interface eco32f_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_adr_o;
    logic        ibus_ack_i;
    logic        ibus_err_i;
    logic [31:0] ibus_dat_i;

    modport master (
        output ibus_req_o,
        output ibus_adr_o,
        input  ibus_ack_i,
        input  ibus_err_i,
        input  ibus_dat_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_adr_o,
        output ibus_ack_i,
        output ibus_err_i,
        output ibus_dat_i
    );
endinterface

// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch: PC owner, single-outstanding ibus reads, ITLB-translated launch.
// Optional ECO32F_FETCH_SKID_EN keeps a word acked under decode stall instead of refetching it.
module eco32f_fetch #(
    parameter logic [31:0] RESET_PC = 32'hE000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    eco32f_fetch_if.master        ibus,
    output logic [31:0]           if_vaddr,
    input  logic [31:0]           itlb_paddr,
    input  logic                  itlb_kmiss,
    input  logic                  itlb_umiss,
    input  logic                  itlb_invalid,
    input  logic                  itlb_priv,
    input  logic                  id_stall,
    input  logic                  exc_taken,
    input  logic [31:0]           exc_vector,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_insn,
    output logic                  id_valid,
    output logic                  id_exc_ibus_fault,
    output logic                  id_exc_itlb_kmiss,
    output logic                  id_exc_itlb_umiss,
    output logic                  id_exc_itlb_invalid,
    output logic                  id_exc_itlb_priv
);

    typedef enum logic [1:0] {IDLE, BUSY, DISCARD, HALT} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        ibus_fault;
        logic        kmiss;
        logic        umiss;
        logic        invalid;
        logic        priv;
    } id_word_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] adr_q, adr_d;
    id_word_t    id_q, id_d;

    logic        itlb_fault;
    logic        launch_ok;
    logic        bus_done;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        skid_busy;

`ifdef ECO32F_FETCH_SKID_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_dat_q, skid_dat_d;
    logic        skid_err_q, skid_err_d;
    assign skid_busy = skid_valid_q;
`else
    assign skid_busy = 1'b0;
`endif

    function automatic id_word_t make_word(input logic [31:0] pc, input logic [31:0] insn,
                                           input logic bus_fault);
        id_word_t w;
        w            = '0;
        w.valid      = 1'b1;
        w.pc         = pc;
        w.insn       = insn;
        w.ibus_fault = bus_fault;
        return w;
    endfunction

    // While BUSY the only possible launch is the back-to-back one, so translate the next word.
    assign if_vaddr    = (state_q == BUSY) ? pc_q + 32'd4 : pc_q;
    assign itlb_fault  = itlb_kmiss | itlb_umiss | itlb_invalid | itlb_priv;
    assign launch_ok   = !itlb_fault && !id_stall && !skid_busy;
    assign bus_done    = ibus.ibus_ack_i | ibus.ibus_err_i;
    assign redirect    = exc_taken | br_taken;
    assign redirect_pc = exc_taken ? exc_vector : br_target;

    always_comb begin
        // NOTE: every _d starts at its hold value so no branch below can leave one unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        adr_d   = adr_q;
        id_d    = id_q;
        if (!id_stall) id_d.valid = 1'b0;
`ifdef ECO32F_FETCH_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_dat_d   = skid_dat_q;
        skid_err_d   = skid_err_q;
`endif

        if (redirect) begin
            pc_d       = redirect_pc;
            id_d.valid = 1'b0;
`ifdef ECO32F_FETCH_SKID_EN
            skid_valid_d = 1'b0;
`endif
            case (state_q)
                BUSY, DISCARD: begin
                    if (bus_done) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (skid_busy) begin
`ifdef ECO32F_FETCH_SKID_EN
                        if (!id_stall) begin
                            id_d         = make_word(skid_pc_q, skid_err_q ? 32'd0 : skid_dat_q,
                                                     skid_err_q);
                            skid_valid_d = 1'b0;
                            if (skid_err_q) state_d = HALT;
                        end
`endif
                    end else if (launch_ok) begin
                        req_d   = 1'b1;
                        adr_d   = {itlb_paddr[31:2], 2'b00};
                        state_d = BUSY;
                    end else if (itlb_fault && !id_stall) begin
                        id_d         = make_word(pc_q, 32'd0, 1'b0);
                        id_d.kmiss   = itlb_kmiss;
                        id_d.umiss   = !itlb_kmiss && itlb_umiss;
                        id_d.invalid = !itlb_kmiss && !itlb_umiss && itlb_invalid;
                        id_d.priv    = !itlb_kmiss && !itlb_umiss && !itlb_invalid && itlb_priv;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HALT;
                    end
                end
                BUSY: begin
                    if (bus_done && !id_stall) begin
                        pc_d = pc_q + 32'd4;
                        if (ibus.ibus_err_i) begin
                            id_d    = make_word(pc_q, 32'd0, 1'b1);
                            req_d   = 1'b0;
                            state_d = HALT;
                        end else begin
                            id_d = make_word(pc_q, ibus.ibus_dat_i, 1'b0);
                            if (launch_ok) begin
                                adr_d = {itlb_paddr[31:2], 2'b00};
                            end else begin
                                req_d   = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end else if (bus_done) begin
                        // Decode is stalled: park the word in the skid, or drop it and refetch later.
                        req_d   = 1'b0;
                        state_d = IDLE;
`ifdef ECO32F_FETCH_SKID_EN
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_dat_d   = ibus.ibus_dat_i;
                        skid_err_d   = ibus.ibus_err_i;
                        pc_d         = pc_q + 32'd4;
`endif
                    end
                end
                DISCARD: begin
                    if (bus_done) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                HALT: begin
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            adr_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            id_q    <= id_d;
        end
    end

`ifdef ECO32F_FETCH_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) skid_valid_q <= 1'b0;
        else     skid_valid_q <= skid_valid_d;
    end

    // NOTE: the skid payload is only read while skid_valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        skid_pc_q  <= skid_pc_d;
        skid_dat_q <= skid_dat_d;
        skid_err_q <= skid_err_d;
    end
`endif

    assign ibus.ibus_req_o   = req_q;
    assign ibus.ibus_adr_o   = adr_q;
    assign id_valid            = id_q.valid;
    assign id_pc               = id_q.pc;
    assign id_insn             = id_q.insn;
    assign id_exc_ibus_fault   = id_q.ibus_fault;
    assign id_exc_itlb_kmiss   = id_q.kmiss;
    assign id_exc_itlb_umiss   = id_q.umiss;
    assign id_exc_itlb_invalid = id_q.invalid;
    assign id_exc_itlb_priv    = id_q.priv;

endmodule

// File: tb/tb_eco32f_fetch.sv
// Directed bench for eco32f_fetch: per-cycle vector table plus hand-written reset sequences.
// Expected values follow the default build and ECO32F_FETCH_SKID_EN where the two differ.
module tb_eco32f_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_vaddr, itlb_paddr;
    logic        itlb_kmiss, itlb_umiss, itlb_invalid, itlb_priv;
    logic        id_stall, exc_taken, br_taken;
    logic [31:0] exc_vector, br_target;
    logic [31:0] id_pc, id_insn;
    logic        id_valid;
    logic        id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss;
    logic        id_exc_itlb_invalid, id_exc_itlb_priv;

    eco32f_fetch_if bus ();

    eco32f_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .ibus                (bus),
        .if_vaddr            (if_vaddr),
        .itlb_paddr          (itlb_paddr),
        .itlb_kmiss          (itlb_kmiss),
        .itlb_umiss          (itlb_umiss),
        .itlb_invalid        (itlb_invalid),
        .itlb_priv           (itlb_priv),
        .id_stall            (id_stall),
        .exc_taken           (exc_taken),
        .exc_vector          (exc_vector),
        .br_taken            (br_taken),
        .br_target           (br_target),
        .id_pc               (id_pc),
        .id_insn             (id_insn),
        .id_valid            (id_valid),
        .id_exc_ibus_fault   (id_exc_ibus_fault),
        .id_exc_itlb_kmiss   (id_exc_itlb_kmiss),
        .id_exc_itlb_umiss   (id_exc_itlb_umiss),
        .id_exc_itlb_invalid (id_exc_itlb_invalid),
        .id_exc_itlb_priv    (id_exc_itlb_priv)
    );

    always #5 clk = ~clk;

    // ITLB model: junk in the low two bits that the fetch must mask off.
    assign itlb_paddr = {if_vaddr[31:2], 2'b11};

    typedef struct {
        logic        ack, err;
        logic [31:0] dat;
        logic        stall, br;
        logic [31:0] tgt;
        logic        exc;
        logic [31:0] evec;
        logic [3:0]  flt;      // {kmiss, umiss, invalid, priv}
        logic        e_req;
        logic [31:0] e_adr;
        logic        e_vld;
        logic [31:0] e_pc, e_insn;
        logic [4:0]  e_flg;    // {ibus_fault, kmiss, umiss, invalid, priv}
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic ack, input logic err, input logic [31:0] dat,
                       input logic stall, input logic br, input logic [31:0] tgt,
                       input logic exc, input logic [31:0] evec, input logic [3:0] flt,
                       input logic e_req, input logic [31:0] e_adr, input logic e_vld,
                       input logic [31:0] e_pc, input logic [31:0] e_insn,
                       input logic [4:0] e_flg);
        vec_t v;
        v.ack = ack; v.err = err; v.dat = dat; v.stall = stall; v.br = br; v.tgt = tgt;
        v.exc = exc; v.evec = evec; v.flt = flt;
        v.e_req = e_req; v.e_adr = e_adr; v.e_vld = e_vld;
        v.e_pc = e_pc; v.e_insn = e_insn; v.e_flg = e_flg;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss,
                id_exc_itlb_invalid, id_exc_itlb_priv};
    endfunction

    task automatic drive_idle();
        bus.ibus_ack_i = 1'b0; bus.ibus_err_i = 1'b0; bus.ibus_dat_i = '0;
        id_stall = 1'b0; br_taken = 1'b0; br_target = '0; exc_taken = 1'b0; exc_vector = '0;
        itlb_kmiss = 1'b0; itlb_umiss = 1'b0; itlb_invalid = 1'b0; itlb_priv = 1'b0;
    endtask

    initial begin
        //  ack err dat          stl br tgt           exc evec          flt      req adr           vld pc            insn          flags
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_0000, 0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h11,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_0004, 1, 32'hE000_0000, 32'h11,       5'b00000);
        add(1, 0, 32'h22,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_0008, 1, 32'hE000_0004, 32'h22,       5'b00000);
        add(1, 0, 32'h33,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_000C, 1, 32'hE000_0008, 32'h33,       5'b00000);
        add(0, 0, 32'h0,         0, 1, 32'h100,       0, 32'h0,         4'b0000, 1, 32'hE000_000C, 0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_000C, 0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_000C, 0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'hDEAD,      0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h100,       0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h44,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h104,       1, 32'h100,       32'h44,       5'b00000);
        add(0, 0, 32'h0,         0, 1, 32'h200,       1, 32'hE000_0004, 4'b0000, 1, 32'h104,       0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'hBAD,       0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_0004, 0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h55,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hE000_0008, 1, 32'hE000_0004, 32'h55,       5'b00000);
        add(1, 0, 32'h66,        0, 1, 32'h1000,      0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0100, 0, 32'h0,         1, 32'h1000,      32'h0,        5'b00100);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 1, 32'h2000,      0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b1001, 0, 32'h0,         1, 32'h2000,      32'h0,        5'b01000);
        add(0, 0, 32'h0,         0, 1, 32'h40,        0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h40,        0, 32'h0,         32'h0,        5'b00000);
        add(0, 1, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         1, 32'h40,        32'h0,        5'b10000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h4,         0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h77,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h8,         1, 32'h4,         32'h77,       5'b00000);
        add(1, 0, 32'h88,        1, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         1, 32'h4,         32'h77,       5'b00000);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         1, 32'h4,         32'h77,       5'b00000);
`ifdef ECO32F_FETCH_SKID_EN
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         1, 32'h8,         32'h88,       5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hC,         0, 32'h0,         32'h0,        5'b00000);
`else
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h8,         0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h88,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hC,         1, 32'h8,         32'h88,       5'b00000);
`endif
        add(0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0,         4'b0000, 1, 32'hC,         0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 0, 32'h0,         0, 32'h0,         32'h0,        5'b00000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        5'b00000);
        add(1, 0, 32'h99,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h99,       5'b00000);
        add(1, 0, 32'hAA,        0, 0, 32'h0,         0, 32'h0,         4'b0000, 1, 32'h4,         1, 32'h0,         32'hAA,       5'b00000);

        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", {127'd0, bus.ibus_req_o}, 128'd0);
        check("reset_id", {id_valid, id_pc, id_insn, flags_now()}, 128'd0);
        check("reset_vaddr", {96'd0, if_vaddr}, {96'd0, 32'hE000_0000});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst            = 1'b0;
            bus.ibus_ack_i = vecs[i].ack;
            bus.ibus_err_i = vecs[i].err;
            bus.ibus_dat_i = vecs[i].dat;
            id_stall       = vecs[i].stall;
            br_taken       = vecs[i].br;
            br_target      = vecs[i].tgt;
            exc_taken      = vecs[i].exc;
            exc_vector     = vecs[i].evec;
            {itlb_kmiss, itlb_umiss, itlb_invalid, itlb_priv} = vecs[i].flt;
            @(posedge clk);
            #1;
            if (vecs[i].e_req)
                check($sformatf("vec%0d_bus", i), {95'd0, bus.ibus_req_o, bus.ibus_adr_o},
                      {95'd0, 1'b1, vecs[i].e_adr});
            else
                check($sformatf("vec%0d_req", i), {127'd0, bus.ibus_req_o}, 128'd0);
            if (vecs[i].e_vld)
                check($sformatf("vec%0d_id", i), {id_valid, id_pc, id_insn, flags_now()},
                      {58'd0, 1'b1, vecs[i].e_pc, vecs[i].e_insn, vecs[i].e_flg});
            else
                check($sformatf("vec%0d_valid", i), {127'd0, id_valid}, 128'd0);
        end

        // Reset while a request is outstanding: abandoned at once, refetch from RESET_PC next cycle.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req", {127'd0, bus.ibus_req_o}, 128'd0);
        check("midrst_id", {id_valid, id_pc, id_insn, flags_now()}, 128'd0);
        check("midrst_vaddr", {96'd0, if_vaddr}, {96'd0, 32'hE000_0000});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_bus", {95'd0, bus.ibus_req_o, bus.ibus_adr_o}, {95'd0, 1'b1, 32'hE000_0000});
        @(negedge clk);
        bus.ibus_ack_i = 1'b1;
        bus.ibus_dat_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("postrst_id", {id_valid, id_pc, id_insn, flags_now()},
              {58'd0, 1'b1, 32'hE000_0000, 32'h1234_5678, 5'b00000});
        check("postrst_next", {95'd0, bus.ibus_req_o, bus.ibus_adr_o}, {95'd0, 1'b1, 32'hE000_0004});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
